add16_err_monitor: RTL

//  Downstream companion to the 16-bit approximate adders. Takes each operand pair

---
 rtl/add16_err_monitor_if.sv | 27 ++
 rtl/add16_err_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/add16_err_monitor_if.sv
// Sample and report channels of the approximate-adder error monitor.
// The producer/consumer side uses the master modport, the monitor uses slave.
interface add16_err_monitor_if #(
  parameter int WIDTH   = 16,
  parameter int LOG_WIN = 10
);
  logic                       in_valid;
  logic                       in_ready;
  logic [WIDTH-1:0]           in_a;
  logic [WIDTH-1:0]           in_b;
  logic [WIDTH:0]             in_sum_approx;
  logic                       out_valid;
  logic                       out_ready;
  logic [WIDTH+LOG_WIN:0]     out_sum_err;
  logic [WIDTH:0]             out_max_err;
  logic [LOG_WIN:0]           out_err_cnt;

  modport master (
    output in_valid, in_a, in_b, in_sum_approx, out_ready,
    input  in_ready, out_valid, out_sum_err, out_max_err, out_err_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sum_approx, out_ready,
    output in_ready, out_valid, out_sum_err, out_max_err, out_err_cnt
  );
endinterface

// File: rtl/add16_err_monitor.sv
// Error monitor for approximate adders: per window of 2**LOG_WIN accepted samples,
// reports sum of |exact-approx|, the worst error and the count of erroneous samples.
module add16_err_monitor #(
  parameter int WIDTH   = 16,
  parameter int LOG_WIN = 10
) (
  input  logic               clk,
  input  logic               rst,
  add16_err_monitor_if.slave bus
);

  localparam int SW = WIDTH + 1;
  localparam int AW = WIDTH + 1 + LOG_WIN;
  localparam int CW = LOG_WIN + 1;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    REPORT
  } state_e;

  state_e             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [LOG_WIN-1:0] smp_cnt_q, smp_cnt_d;

  // S0: captured operands, S1: error, then the fold into the accumulators.
  logic               s0_valid_q, s0_valid_d;
  logic               s0_last_q, s0_last_d;
  logic [WIDTH-1:0]   s0_a_q, s0_a_d;
  logic [WIDTH-1:0]   s0_b_q, s0_b_d;
  logic [SW-1:0]      s0_approx_q, s0_approx_d;
  logic               s1_valid_q, s1_valid_d;
  logic               s1_last_q, s1_last_d;
  logic [SW-1:0]      s1_err_q, s1_err_d;
  logic               s1_nz_q, s1_nz_d;
  logic               acc_last_q, acc_last_d;

  logic [AW-1:0]      acc_sum_q, acc_sum_d;
  logic [SW-1:0]      acc_max_q, acc_max_d;
  logic [CW-1:0]      acc_cnt_q, acc_cnt_d;
  logic [AW-1:0]      out_sum_q, out_sum_d;
  logic [SW-1:0]      out_max_q, out_max_d;
  logic [CW-1:0]      out_cnt_q, out_cnt_d;

  logic               accept;
  logic [SW-1:0]      exact;
  logic [SW-1:0]      err;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    s0_valid_d  = 1'b0;
    s0_last_d   = 1'b0;
    s0_a_d      = s0_a_q;
    s0_b_d      = s0_b_q;
    s0_approx_d = s0_approx_q;
    s1_valid_d  = s0_valid_q;
    s1_last_d   = s0_last_q;
    s1_err_d    = s1_err_q;
    s1_nz_d     = s1_nz_q;
    acc_last_d  = s1_valid_q && s1_last_q;
    acc_sum_d   = acc_sum_q;
    acc_max_d   = acc_max_q;
    acc_cnt_d   = acc_cnt_q;
    out_sum_d   = out_sum_q;
    out_max_d   = out_max_q;
    out_cnt_d   = out_cnt_q;

    accept = bus.in_valid && in_ready_q;
    exact  = {1'b0, s0_a_q} + {1'b0, s0_b_q};
    err    = (exact >= s0_approx_q) ? (exact - s0_approx_q) : (s0_approx_q - exact);

    if (accept) begin
      s0_valid_d  = 1'b1;
      s0_last_d   = (smp_cnt_q == {LOG_WIN{1'b1}});
      s0_a_d      = bus.in_a;
      s0_b_d      = bus.in_b;
      s0_approx_d = bus.in_sum_approx;
      smp_cnt_d   = smp_cnt_q + 1'b1;
    end

    if (s0_valid_q) begin
      s1_err_d = err;
      s1_nz_d  = (err != '0);
    end

    if (s1_valid_q) begin
      acc_sum_d = acc_sum_q + AW'(s1_err_q);
      acc_cnt_d = acc_cnt_q + CW'(s1_nz_q);
      if (s1_err_q > acc_max_q) acc_max_d = s1_err_q;
    end

    case (state_q)
      ACCUM: begin
        if (accept && s0_last_d) state_d = DRAIN;
      end
      // Wait until the window's last sample has left the fold stage.
      DRAIN: begin
        if (acc_last_q) begin
          out_sum_d = acc_sum_q;
          out_max_d = acc_max_q;
          out_cnt_d = acc_cnt_q;
          state_d   = REPORT;
        end
      end
      REPORT: begin
        if (bus.out_ready) begin
          acc_sum_d = '0;
          acc_max_d = '0;
          acc_cnt_d = '0;
          state_d   = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase

    in_ready_d  = (state_d == ACCUM);
    out_valid_d = (state_d == REPORT);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      smp_cnt_q   <= '0;
      s0_valid_q  <= 1'b0;
      s0_last_q   <= 1'b0;
      s0_a_q      <= '0;
      s0_b_q      <= '0;
      s0_approx_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_err_q    <= '0;
      s1_nz_q     <= 1'b0;
      acc_last_q  <= 1'b0;
      acc_sum_q   <= '0;
      acc_max_q   <= '0;
      acc_cnt_q   <= '0;
      out_sum_q   <= '0;
      out_max_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      smp_cnt_q   <= smp_cnt_d;
      s0_valid_q  <= s0_valid_d;
      s0_last_q   <= s0_last_d;
      s0_a_q      <= s0_a_d;
      s0_b_q      <= s0_b_d;
      s0_approx_q <= s0_approx_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_err_q    <= s1_err_d;
      s1_nz_q     <= s1_nz_d;
      acc_last_q  <= acc_last_d;
      acc_sum_q   <= acc_sum_d;
      acc_max_q   <= acc_max_d;
      acc_cnt_q   <= acc_cnt_d;
      out_sum_q   <= out_sum_d;
      out_max_q   <= out_max_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_sum_err = out_sum_q;
  assign bus.out_max_err = out_max_q;
  assign bus.out_err_cnt = out_cnt_q;

endmodule
